// File: rtl/hazard_scoreboard.sv
// Register-writing instructions in flight between ID and WB, compared against the
// ID source fields to stall IF/ID and bubble EXE on a read-after-write hazard.
module hazard_scoreboard #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               fwd_en,
  input  logic               id_valid,
  input  logic               id_wb_en,
  input  logic               id_mem_r_en,
  input  logic [3:0]         id_dest,
  input  logic [3:0]         id_src1,
  input  logic               id_uses_src1,
  input  logic [3:0]         id_src2,
  input  logic               id_two_src,
  output logic               hazard,
  output logic [DEPTH-1:0]   stage_valid,
  output logic [4*DEPTH-1:0] stage_dest,
  output logic [DEPTH-1:0]   stage_load,
  output logic [CNT_W-1:0]   hazard_cnt
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] load_q;
  logic [3:0]       dest_q [DEPTH];
  logic [DEPTH-1:0] match;
  logic             hazard_c;
  logic             issue;

  // With forwarding, only a load still in EXE cannot supply its result in time.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] &
                 ((id_uses_src1 & (id_src1 == dest_q[i])) |
                  (id_two_src   & (id_src2 == dest_q[i])));
    end
    hazard_c = 1'b0;
    if (id_valid && !flush) begin
      if (fwd_en) hazard_c = match[0] & load_q[0];
      else        hazard_c = |match;
    end
  end

  assign issue  = id_valid & id_wb_en & ~hazard_c & ~flush;
  assign hazard = hazard_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      load_q     <= '0;
      hazard_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) dest_q[i] <= '0;
    end else if (!freeze) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        valid_q[i] <= valid_q[i-1];
        load_q[i]  <= load_q[i-1];
        dest_q[i]  <= dest_q[i-1];
      end
      valid_q[0] <= issue;
      load_q[0]  <= issue & id_mem_r_en;
      dest_q[0]  <= issue ? id_dest : 4'd0;
      if (hazard_c && (hazard_cnt != {CNT_W{1'b1}}))
        hazard_cnt <= hazard_cnt + 1'b1;
    end
  end

  always_comb begin
    stage_dest = '0;
    for (int i = 0; i < DEPTH; i++) stage_dest[4*i +: 4] = dest_q[i];
  end

  assign stage_valid = valid_q;
  assign stage_load  = load_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a queue-based
// model of the in-flight instruction window.
module tb_hazard_scoreboard;
  localparam int DEPTH = 2;
  localparam int CNT_W = 5;
  localparam int SW    = 2 * DEPTH + 4 * DEPTH + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic clk, rst, freeze, flush, fwd_en;
  logic id_valid, id_wb_en, id_mem_r_en, id_uses_src1, id_two_src;
  logic [3:0] id_dest, id_src1, id_src2;
  logic hazard;
  logic [DEPTH-1:0]   stage_valid, stage_load;
  logic [4*DEPTH-1:0] stage_dest;
  logic [CNT_W-1:0]   hazard_cnt;

  hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .id_src1(id_src1), .id_uses_src1(id_uses_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .hazard(hazard),
    .stage_valid(stage_valid), .stage_dest(stage_dest),
    .stage_load(stage_load), .hazard_cnt(hazard_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: in-flight window, youngest first, bubbles included
  typedef struct packed {
    bit       valid;
    bit [3:0] dest;
    bit       load;
  } ent_t;

  ent_t             pipe[$];
  logic [CNT_W-1:0] m_cnt;
  logic [SW-1:0]    exp_q[$];

  function automatic bit model_hazard();
    bit h = 1'b0;
    if (!id_valid || flush) return 1'b0;
    foreach (pipe[i]) begin
      if (pipe[i].valid && ((id_uses_src1 && id_src1 == pipe[i].dest) ||
                            (id_two_src && id_src2 == pipe[i].dest))) begin
        if (!fwd_en) h = 1'b1;
        else if (i == 0 && pipe[i].load) h = 1'b1;
      end
    end
    return h;
  endfunction

  function automatic logic [SW-1:0] snapshot();
    logic [DEPTH-1:0]   v = '0;
    logic [DEPTH-1:0]   l = '0;
    logic [4*DEPTH-1:0] d = '0;
    foreach (pipe[i]) begin
      v[i] = pipe[i].valid;
      l[i] = pipe[i].load;
      d[4*i +: 4] = pipe[i].dest;
    end
    return {v, d, l, m_cnt};
  endfunction

  task automatic model_clear();
    pipe = {};
    repeat (DEPTH) pipe.push_back('0);
    m_cnt = '0;
    exp_q = {};
    exp_q.push_back(snapshot());
  endtask

  // driver tasks
  task automatic id_idle();
    id_valid = 0; id_wb_en = 0; id_mem_r_en = 0; id_dest = 0;
    id_src1 = 0; id_uses_src1 = 0; id_src2 = 0; id_two_src = 0;
  endtask

  task automatic id_set(input bit wb, input bit ld, input logic [3:0] d,
                        input bit u1, input logic [3:0] s1, input bit two, input logic [3:0] s2);
    id_valid = 1; id_wb_en = wb; id_mem_r_en = ld; id_dest = d;
    id_uses_src1 = u1; id_src1 = s1; id_two_src = two; id_src2 = s2;
  endtask

  // compare outputs against the model, away from the rising edge
  task automatic eval();
    logic [SW-1:0] e;
    #1;
    e = exp_q[0];
    chk("hazard", {31'd0, hazard}, {31'd0, model_hazard()});
    chk("stage", {stage_valid, stage_dest, stage_load, hazard_cnt}, e);
  endtask

  // advance one clock and update the model with the inputs seen at the edge
  task automatic step();
    bit h, iss;
    h = model_hazard();
    @(posedge clk);
    if (!freeze) begin
      iss = id_valid && id_wb_en && !h && !flush;
      pipe.push_front('{valid: iss, dest: iss ? id_dest : 4'd0, load: iss && id_mem_r_en});
      void'(pipe.pop_back());
      if (h && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
    end
    void'(exp_q.pop_front());
    exp_q.push_back(snapshot());
    @(negedge clk);
  endtask

  task automatic tick();
    eval();
    step();
  endtask

  initial begin
    rst = 0; freeze = 0; flush = 0; fwd_en = 0;
    id_idle();
    model_clear();
    @(negedge clk);
    eval();
    chk("reset_cnt", {27'd0, hazard_cnt}, 32'd0);
    @(negedge clk);
    rst = 1;

    // 1: ADD R1 then SUB reading R1, no forwarding
    id_set(1, 0, 4'd1, 1, 4'd2, 1, 4'd3); tick();
    id_set(1, 0, 4'd6, 1, 4'd1, 0, 4'd0);
    eval(); chk("t1_haz0", {31'd0, hazard}, 32'd1); step();
    eval(); chk("t1_haz1", {31'd0, hazard}, 32'd1); step();
    eval(); chk("t1_clear", {31'd0, hazard}, 32'd0);
    chk("t1_cnt", {27'd0, hazard_cnt}, 32'd2); step();

    // 2: load-use with forwarding stalls once; non-load producer does not stall
    fwd_en = 1;
    id_set(1, 1, 4'd2, 0, 4'd0, 0, 4'd0); tick();
    id_set(1, 0, 4'd8, 1, 4'd7, 1, 4'd2);
    eval(); chk("t2_lu", {31'd0, hazard}, 32'd1); step();
    eval(); chk("t2_lu_done", {31'd0, hazard}, 32'd0); step();
    id_set(1, 0, 4'd9, 0, 4'd0, 0, 4'd0); tick();
    id_set(1, 0, 4'd3, 1, 4'd9, 0, 4'd0);
    eval(); chk("t2_alu_fwd", {31'd0, hazard}, 32'd0); step();

    // 3: unused source fields never match
    fwd_en = 0;
    id_set(1, 0, 4'd10, 0, 4'd0, 0, 4'd0); tick();
    id_set(0, 0, 4'd0, 1, 4'd11, 0, 4'd10);
    eval(); chk("t3_src2_unused", {31'd0, hazard}, 32'd0);
    id_set(0, 0, 4'd0, 0, 4'd10, 0, 4'd4);
    eval(); chk("t3_src1_unused", {31'd0, hazard}, 32'd0); step();

    // 4: freeze holds tracking and counter while a hazard is visible
    id_set(1, 0, 4'd4, 0, 4'd0, 0, 4'd0); tick();
    freeze = 1;
    id_set(0, 0, 4'd0, 1, 4'd4, 1, 4'd4);
    repeat (3) begin
      eval();
      chk("t4_hold_v", {31'd0, stage_valid[0]}, 32'd1);
      chk("t4_hold_d", {28'd0, stage_dest[3:0]}, 32'd4);
      step();
    end
    freeze = 0;
    tick();
    chk("t4_moved_v", {30'd0, stage_valid}, 32'd2);
    chk("t4_moved_d", {28'd0, stage_dest[7:4]}, 32'd4);

    // 5: flush beats a matching hazard
    id_idle(); tick();
    id_set(1, 0, 4'd5, 0, 4'd0, 0, 4'd0); tick();
    flush = 1;
    id_set(1, 0, 4'd12, 1, 4'd5, 1, 4'd5);
    eval(); chk("t5_flush_haz", {31'd0, hazard}, 32'd0); step();
    flush = 0;
    id_idle();
    eval(); chk("t5_bubble", {31'd0, stage_valid[0]}, 32'd0); step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      freeze = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) fwd_en = ~fwd_en;
      id_set($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 5)),
             $urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)),
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 5)));
      id_valid = ($urandom_range(0, 7) != 0);
      tick();
    end
    freeze = 0; flush = 0; fwd_en = 0;

    // 6: asynchronous reset in the middle of a stall
    id_set(1, 0, 4'd1, 0, 4'd0, 0, 4'd0); tick();
    id_set(1, 0, 4'd2, 1, 4'd1, 0, 4'd0); tick();
    #2 rst = 0;
    #1;
    chk("t6_rst_valid", {30'd0, stage_valid}, 32'd0);
    chk("t6_rst_cnt", {27'd0, hazard_cnt}, 32'd0);
    chk("t6_rst_haz", {31'd0, hazard}, 32'd0);
    model_clear();
    #1 rst = 1;
    id_idle();
    @(negedge clk);

    // saturation: 2 hazard cycles per producer/consumer pair
    for (int n = 0; n < 20; n++) begin
      id_set(1, 0, 4'd7, 0, 4'd0, 0, 4'd0); tick();
      id_set(1, 0, 4'd8, 0, 4'd0, 1, 4'd7);
      repeat (3) tick();
    end
    id_idle(); eval();
    chk("sat_cnt", {27'd0, hazard_cnt}, {27'd0, CNT_MAX});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
